// File: rtl/dcache_pkg.sv
// Shared types and geometry for the write-through data cache controller.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

  localparam int INDEX_W_DEF = 5;
  localparam int OFFS_W_DEF  = 2;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Tag width: byte address minus index, word offset and byte-in-word bits.
  function automatic int tag_width(input int addr_w, input int index_w, input int offs_w);
    return addr_w - index_w - offs_w - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped cache: combinational lookup,
// synchronous word writes and line tag/valid set; valid bits clear on rst.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFS_W  = OFFS_W_DEF,
  parameter int TAG_W   = tag_width(ADDR_W_DEF, INDEX_W_DEF, OFFS_W_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [OFFS_W-1:0]  rd_offs,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [OFFS_W-1:0]  wr_offs,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               set_en,
  input  logic [TAG_W-1:0]   set_tag
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFS_W);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [WORDS];

  always_comb begin
    valid_d = valid_q;
    if (set_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_mem[wr_index] <= set_tag;
    end
    if (wr_en) begin
      data_mem[{wr_index, wr_offs}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offs}];

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Write-through, no-write-allocate, direct-mapped data cache controller (MEM stage).
// Define DCACHE_STATS_EN to add saturating hit/miss/write counters.
module dcache_wt_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFS_W  = OFFS_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes
`endif
);

  localparam int TAG_W   = tag_width(ADDR_W, INDEX_W, OFFS_W);
  localparam int LSB_IDX = OFFS_W + 2;
  localparam int LSB_TAG = OFFS_W + INDEX_W + 2;
  localparam logic [OFFS_W-1:0] CNT_ONE  = 1;
  localparam logic [OFFS_W-1:0] CNT_LAST = '1;

  state_e              state_q, state_d;
  logic [OFFS_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [ADDR_W-1:0]   lk_addr;
  logic [INDEX_W-1:0]  lk_index;
  logic [OFFS_W-1:0]   lk_offs;
  logic [TAG_W-1:0]    lk_tag;
  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [31:0]         arr_data;
  logic                hit;

  logic                arr_wr_en;
  logic [OFFS_W-1:0]   arr_wr_offs;
  logic [31:0]         arr_wr_data;
  logic                arr_set_en;

  logic [1:0]          unused_addr_bits;
  assign unused_addr_bits = cpu_addr[1:0];

  // In IDLE the live CPU address is looked up; otherwise the latched one.
  assign lk_addr  = (state_q == ST_IDLE) ? cpu_addr : addr_q;
  assign lk_offs  = lk_addr[LSB_IDX-1:2];
  assign lk_index = lk_addr[LSB_TAG-1:LSB_IDX];
  assign lk_tag   = lk_addr[ADDR_W-1:LSB_TAG];
  assign hit      = arr_valid && (arr_tag == lk_tag);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .OFFS_W  (OFFS_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (lk_index),
    .rd_offs  (lk_offs),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (arr_wr_en),
    .wr_index (addr_q[LSB_TAG-1:LSB_IDX]),
    .wr_offs  (arr_wr_offs),
    .wr_data  (arr_wr_data),
    .set_en   (arr_set_en),
    .set_tag  (addr_q[ADDR_W-1:LSB_TAG])
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata   = '0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    arr_wr_en   = 1'b0;
    arr_set_en  = 1'b0;
    arr_wr_offs = addr_q[LSB_IDX-1:2];
    arr_wr_data = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_wr) begin
          stall   = 1'b1;
          addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
          wdata_d = cpu_wdata;
          state_d = ST_WRITE;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = arr_data;
          end else begin
            stall   = 1'b1;
            addr_d  = {cpu_addr[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
            cnt_d   = '0;
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        stall       = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {addr_q[ADDR_W-1:LSB_IDX], cnt_q, 2'b00};
        arr_wr_offs = cnt_q;
        arr_wr_data = mem_rdata;
        if (mem_ready) begin
          arr_wr_en = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
          // Tag/valid are published only with the last word, so an
          // interrupted fill never leaves a half-written line visible.
          if (cnt_q == CNT_LAST) begin
            arr_set_en = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          stall     = 1'b0;
          arr_wr_en = hit;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) begin
      cpu_rdata  = '0;
      stall      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      arr_wr_en  = 1'b0;
      arr_set_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic [31:0] writes_q, writes_d;
  logic        hit_evt, miss_evt, write_evt;

  assign hit_evt   = (state_q == ST_IDLE) && !cpu_wr && cpu_rd && hit;
  assign miss_evt  = (state_q == ST_IDLE) && !cpu_wr && cpu_rd && !hit;
  assign write_evt = (state_q == ST_WRITE) && mem_ready;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    writes_d = writes_q;
    if (hit_evt && (hits_q != '1)) begin
      hits_d = hits_q + 32'd1;
    end
    if (miss_evt && (misses_q != '1)) begin
      misses_d = misses_q + 32'd1;
    end
    if (write_evt && (writes_q != '1)) begin
      writes_d = writes_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      writes_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      writes_q <= writes_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_writes = writes_q;
`endif

endmodule
